sme_scan_ctrl: RTL and testbench
================================

# sme_scan_ctrl

Parametrised control FSM for the string-matching engine. It tracks string and pattern load lengths, drives write enables and addresses into the datapath buffers, and sequences a pipelined scan of candidate start positions. It collects the datapath's per-position hit and reports the first match index with a one-cycle `valid`. It sits between the input stream (`isstring` / `ispattern`) and the character buffers plus comparator array.

## Interface
- `STR_MAX`, 32: string buffer depth (characters); power of two, ≥ 2.
- `PAT_MAX`, 8: pattern buffer depth; power of two, ≥ 2, ≤ `STR_MAX`.
- `IDX_W`, `$clog2(STR_MAX)+1`: width of string index/length.
- `PAT_W`, `$clog2(PAT_MAX)+1`: width of pattern index/length.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `isstring` in 1: current input char belongs to a string.
- `ispattern` in 1: current input char belongs to a pattern.
- `cmp_hit` in 1: datapath result for the position issued the previous cycle.
- `str_we` out 1: string buffer write enable.
- `str_addr` out IDX_W: string write address.
- `pat_we` out 1: pattern buffer write enable.
- `pat_addr` out PAT_W: pattern write address.
- `cmp_go` out 1: comparator issue strobe.
- `cmp_pos` out IDX_W: candidate start position being issued.
- `match` out 1: match found (qualified by `valid`).
- `match_index` out IDX_W: first matching start position; 0 if no match.
- `valid` out 1: result strobe, one cycle.
- `state` out 2: 00 IDLE, 01 READ, 11 SCAN, 10 REPORT.

## Operation
- **IDLE → READ** unconditionally on the first clock after reset.
- **READ, `isstring`:**
  - The first `isstring` cycle after a non-`isstring` cycle clears `str_len`.
  - Each cycle with `str_len < STR_MAX`: `str_we=1`, `str_addr=str_len`, then `str_len++`.
  - At `STR_MAX` the character is dropped: `str_we=0`, length holds.
- **READ, `ispattern`:** same rules applied to `pat_len`, `pat_we`, `pat_addr`, saturating at `PAT_MAX`.
- **Both inputs high:** treated as `isstring`; the pattern side is ignored.
- **Both inputs low in READ:**
  - If `pat_len != 0`, go to SCAN.
  - Otherwise stay in READ. `str_len` is retained, so several patterns can be matched against one string.
- **SCAN:**
  - Last position `L = str_len - pat_len`. If `pat_len > str_len` or `str_len == 0`, go to REPORT with no match; zero `cmp_go` pulses are issued.
  - Otherwise issue `cmp_go=1` with `cmp_pos = 0, 1, …, L`, one position per cycle.
  - `cmp_hit` is sampled the cycle after each issue.
  - The first sampled hit at position p latches `match=1`, `match_index=p`, stops issue and goes to REPORT. Any in-flight result for p+1 is discarded.
  - After the result for L is sampled with no hit: `match=0`, `match_index=0`, go to REPORT.
- **REPORT:**
  - `valid=1` for exactly one cycle. `match` and `match_index` hold until the next REPORT.
  - Clear `pat_len`, then go to READ.
  - Inputs arriving during SCAN or REPORT are ignored.

## Timing
- Reset values: all outputs 0, `state=00`, `str_len=pat_len=0`, `match_index=0`.
- `str_we`, `pat_we` and addresses are combinational from state and inputs, in the same cycle as the input character.
- SCAN latency with no hit: L+1 issue cycles + 1 drain cycle, then REPORT.
- A hit at p enters REPORT on the cycle after `cmp_hit` is sampled. `valid` rises p+2 cycles after the first SCAN cycle.
- `rst` mid-scan: immediate return to IDLE, all outputs 0; no `valid` is produced.

## Configuration
- **`SME_SCAN_CTRL_MATCHCNT_EN` defined:**
  - Adds output `match_cnt` (IDX_W): the number of hits across all positions.
  - SCAN never terminates early; it always issues 0..L.
  - `match_index` is the first hit; `match_cnt` holds alongside `match` and resets to 0.
- **Undefined:** no `match_cnt` port; early termination on first hit as above.

## Test plan
- **Basic first match:** string of 8 chars, pattern of 3 chars, `cmp_hit` asserted for pos 2 → 6 `cmp_go` pulses max; issue stops after pos 3; `valid=1`, `match=1`, `match_index=2`; `str_addr` 0..7 and `pat_addr` 0..2 observed during load.
- **No match:** string 5, pattern 2, `cmp_hit` never asserted → `cmp_pos` 0..3; REPORT 5 cycles after SCAN entry; `match=0`, `match_index=0`.
- **Pattern longer than string:** string 2, pattern 4 → zero `cmp_go`; `valid` on the cycle after SCAN; `match=0`.
- **Saturation and reuse:** 40 string chars with `STR_MAX=32` → `str_we` low for the last 8. Two consecutive patterns each scan the 32-char string; `str_len` is retained.
- **Simultaneous inputs and early termination:** `isstring` and `ispattern` both high → only `str_we` pulses. With `MATCHCNT_EN`, hits at pos 1 and 4 → `match_index=1`, `match_cnt=2`, full 0..L issued.
- **Reset mid-scan:** `rst` asserted at pos 3 → same-cycle `state=00`, outputs 0, no `valid`; after release, READ on the next cycle.

Source files
------------

// File: rtl/sme_scan_ctrl.sv
// Control FSM for the string-matching engine: loads string/pattern lengths, issues candidate scan positions, reports the first match.
// Optional build macro SME_SCAN_CTRL_MATCHCNT_EN adds a match_cnt output and full-length (non-terminating) scans.
module sme_scan_ctrl #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int IDX_W   = $clog2(STR_MAX) + 1,
  parameter int PAT_W   = $clog2(PAT_MAX) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             isstring,
  input  logic             ispattern,
  input  logic             cmp_hit,
  output logic             str_we,
  output logic [IDX_W-1:0] str_addr,
  output logic             pat_we,
  output logic [PAT_W-1:0] pat_addr,
  output logic             cmp_go,
  output logic [IDX_W-1:0] cmp_pos,
  output logic             match,
  output logic [IDX_W-1:0] match_index,
  output logic             valid,
  output logic [1:0]       state
`ifdef SME_SCAN_CTRL_MATCHCNT_EN
  ,output logic [IDX_W-1:0] match_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    READ   = 2'b01,
    SCAN   = 2'b11,
    REPORT = 2'b10
  } state_t;

  localparam logic [IDX_W-1:0] STR_FULL = IDX_W'(STR_MAX);
  localparam logic [PAT_W-1:0] PAT_FULL = PAT_W'(PAT_MAX);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] str_len_reg, str_len_next;
  logic [PAT_W-1:0] pat_len_reg, pat_len_next;
  logic             str_run_reg, str_run_next;
  logic             pat_run_reg, pat_run_next;
  logic [IDX_W-1:0] issue_pos_reg, issue_pos_next;
  logic             issue_done_reg, issue_done_next;
  logic             pend_reg, pend_next;
  logic [IDX_W-1:0] pend_pos_reg, pend_pos_next;
  logic             match_reg, match_next;
  logic [IDX_W-1:0] match_index_reg, match_index_next;
`ifdef SME_SCAN_CTRL_MATCHCNT_EN
  logic             found_reg, found_next;
  logic [IDX_W-1:0] first_reg, first_next;
  logic [IDX_W-1:0] cnt_acc_reg, cnt_acc_next;
  logic [IDX_W-1:0] match_cnt_reg, match_cnt_next;
`endif

  logic [IDX_W-1:0] s_base;
  logic [PAT_W-1:0] p_base;
  logic [IDX_W-1:0] pat_ext;
  logic [IDX_W-1:0] last_pos;
  logic             skip_scan;
  logic             hit_now;
  logic             final_res;

  assign pat_ext   = IDX_W'(pat_len_reg);
  assign last_pos  = str_len_reg - pat_ext;
  assign skip_scan = (pat_ext > str_len_reg) || (str_len_reg == '0);
  // cmp_hit is only meaningful when a position was issued on the previous cycle
  assign hit_now   = pend_reg && cmp_hit;
  assign final_res = pend_reg && (pend_pos_reg == last_pos);

  always_comb begin
    state_next       = state_reg;
    str_len_next     = str_len_reg;
    pat_len_next     = pat_len_reg;
    str_run_next     = str_run_reg;
    pat_run_next     = pat_run_reg;
    issue_pos_next   = issue_pos_reg;
    issue_done_next  = issue_done_reg;
    pend_next        = pend_reg;
    pend_pos_next    = pend_pos_reg;
    match_next       = match_reg;
    match_index_next = match_index_reg;
`ifdef SME_SCAN_CTRL_MATCHCNT_EN
    found_next       = found_reg;
    first_next       = first_reg;
    cnt_acc_next     = cnt_acc_reg;
    match_cnt_next   = match_cnt_reg;
`endif
    s_base   = str_run_reg ? str_len_reg : '0;
    p_base   = pat_run_reg ? pat_len_reg : '0;
    str_we   = 1'b0;
    str_addr = '0;
    pat_we   = 1'b0;
    pat_addr = '0;
    cmp_go   = 1'b0;
    cmp_pos  = '0;
    valid    = 1'b0;

    case (state_reg)
      IDLE: state_next = READ;

      READ: begin
        str_run_next = isstring;
        pat_run_next = ispattern && !isstring;
        if (isstring) begin
          if (s_base < STR_FULL) begin
            str_we       = 1'b1;
            str_addr     = s_base;
            str_len_next = s_base + IDX_W'(1);
          end else begin
            str_len_next = s_base;
          end
        end else if (ispattern) begin
          if (p_base < PAT_FULL) begin
            pat_we       = 1'b1;
            pat_addr     = p_base;
            pat_len_next = p_base + PAT_W'(1);
          end else begin
            pat_len_next = p_base;
          end
        end else if (pat_len_reg != '0) begin
          state_next      = SCAN;
          issue_pos_next  = '0;
          issue_done_next = 1'b0;
          pend_next       = 1'b0;
`ifdef SME_SCAN_CTRL_MATCHCNT_EN
          found_next      = 1'b0;
          first_next      = '0;
          cnt_acc_next    = '0;
`endif
        end
      end

      SCAN: begin
        str_run_next = 1'b0;
        pat_run_next = 1'b0;
        if (skip_scan) begin
          state_next       = REPORT;
          match_next       = 1'b0;
          match_index_next = '0;
`ifdef SME_SCAN_CTRL_MATCHCNT_EN
          match_cnt_next   = '0;
`endif
        end else begin
          // Issue runs one position ahead of the result being sampled
          cmp_go = !issue_done_reg;
          if (cmp_go) begin
            cmp_pos = issue_pos_reg;
            if (issue_pos_reg == last_pos) issue_done_next = 1'b1;
            else issue_pos_next = issue_pos_reg + IDX_W'(1);
          end
          pend_next     = cmp_go;
          pend_pos_next = issue_pos_reg;
`ifdef SME_SCAN_CTRL_MATCHCNT_EN
          if (hit_now) begin
            cnt_acc_next = cnt_acc_reg + IDX_W'(1);
            if (!found_reg) begin
              found_next = 1'b1;
              first_next = pend_pos_reg;
            end
          end
          if (final_res) begin
            state_next       = REPORT;
            match_next       = found_reg || hit_now;
            match_index_next = found_reg ? first_reg : (hit_now ? pend_pos_reg : '0);
            match_cnt_next   = cnt_acc_reg + (hit_now ? IDX_W'(1) : IDX_W'(0));
          end
`else
          if (hit_now) begin
            state_next       = REPORT;
            match_next       = 1'b1;
            match_index_next = pend_pos_reg;
          end else if (final_res) begin
            state_next       = REPORT;
            match_next       = 1'b0;
            match_index_next = '0;
          end
`endif
        end
      end

      REPORT: begin
        valid        = 1'b1;
        pat_len_next = '0;
        str_run_next = 1'b0;
        pat_run_next = 1'b0;
        state_next   = READ;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      str_len_reg     <= '0;
      pat_len_reg     <= '0;
      str_run_reg     <= 1'b0;
      pat_run_reg     <= 1'b0;
      issue_pos_reg   <= '0;
      issue_done_reg  <= 1'b0;
      pend_reg        <= 1'b0;
      pend_pos_reg    <= '0;
      match_reg       <= 1'b0;
      match_index_reg <= '0;
`ifdef SME_SCAN_CTRL_MATCHCNT_EN
      found_reg       <= 1'b0;
      first_reg       <= '0;
      cnt_acc_reg     <= '0;
      match_cnt_reg   <= '0;
`endif
    end else begin
      state_reg       <= state_next;
      str_len_reg     <= str_len_next;
      pat_len_reg     <= pat_len_next;
      str_run_reg     <= str_run_next;
      pat_run_reg     <= pat_run_next;
      issue_pos_reg   <= issue_pos_next;
      issue_done_reg  <= issue_done_next;
      pend_reg        <= pend_next;
      pend_pos_reg    <= pend_pos_next;
      match_reg       <= match_next;
      match_index_reg <= match_index_next;
`ifdef SME_SCAN_CTRL_MATCHCNT_EN
      found_reg       <= found_next;
      first_reg       <= first_next;
      cnt_acc_reg     <= cnt_acc_next;
      match_cnt_reg   <= match_cnt_next;
`endif
    end
  end

  assign state       = state_reg;
  assign match       = match_reg;
  assign match_index = match_index_reg;
`ifdef SME_SCAN_CTRL_MATCHCNT_EN
  assign match_cnt   = match_cnt_reg;
`endif

endmodule

// File: tb/tb_sme_scan_ctrl.sv
// Directed, table-driven bench for sme_scan_ctrl; also covers the SME_SCAN_CTRL_MATCHCNT_EN build.
module tb_sme_scan_ctrl;
  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int IDX_W   = 6;
  localparam int PAT_W   = 4;
`ifdef SME_SCAN_CTRL_MATCHCNT_EN
  localparam int NV = 21;
`else
  localparam int NV = 18;
`endif

  logic             clk = 1'b0;
  logic             rst, isstring, ispattern, cmp_hit;
  logic             str_we, pat_we, cmp_go, match, valid;
  logic [IDX_W-1:0] str_addr, cmp_pos, match_index;
  logic [PAT_W-1:0] pat_addr;
  logic [1:0]       state;
`ifdef SME_SCAN_CTRL_MATCHCNT_EN
  logic [IDX_W-1:0] match_cnt;
`endif

  sme_scan_ctrl #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .IDX_W(IDX_W), .PAT_W(PAT_W)) dut (
    .clk(clk), .rst(rst), .isstring(isstring), .ispattern(ispattern), .cmp_hit(cmp_hit),
    .str_we(str_we), .str_addr(str_addr), .pat_we(pat_we), .pat_addr(pat_addr),
    .cmp_go(cmp_go), .cmp_pos(cmp_pos), .match(match), .match_index(match_index),
    .valid(valid), .state(state)
`ifdef SME_SCAN_CTRL_MATCHCNT_EN
    , .match_cnt(match_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        s;
    logic        p;
    logic        h;
    logic [28:0] exp;
  } vec_t;
  vec_t vecs[NV];

  logic [28:0] act_vec;
  assign act_vec = {str_we, str_addr, pat_we, pat_addr, cmp_go, cmp_pos, valid, match, match_index, state};

  function automatic vec_t mk(input logic s, input logic p, input logic h,
                              input logic swe, input logic [5:0] sa, input logic pwe, input logic [3:0] pa,
                              input logic go, input logic [5:0] pos, input logic v, input logic m,
                              input logic [5:0] mi, input logic [1:0] st);
    vec_t r;
    r.s = s; r.p = p; r.h = h;
    r.exp = {swe, sa, pwe, pa, go, pos, v, m, mi, st};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge and let combinational outputs settle
  task automatic cyc(input logic s, input logic p, input logic h);
    @(negedge clk);
    isstring = s; ispattern = p; cmp_hit = h;
    #1;
  endtask

  task automatic load_str(input int n, input logic both);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, both, 1'b0);
      chk("str_we", str_we, (i < STR_MAX) ? 1 : 0);
      if (i < STR_MAX) chk("str_addr", str_addr, i);
      chk("pat_we_during_str", pat_we, 0);
    end
  endtask

  task automatic load_pat(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk("pat_we", pat_we, 1);
      chk("pat_addr", pat_addr, i);
      chk("str_we_during_pat", str_we, 0);
    end
  endtask

  // Scan cycles counted from the first SCAN cycle (k=0); cmp_hit at k answers position k-1
  task automatic run_scan(input int h1, input int h2, output int pulses, output int lastp,
                          output int rep, output logic m, output logic [5:0] mi);
    bit done;
    done = 0; pulses = 0; lastp = -1; rep = -1; m = 1'bx; mi = 'x;
    for (int k = 0; k < 80 && !done; k++) begin
      cyc(1'b0, 1'b0, ((k - 1) == h1) || ((k - 1) == h2));
      if (state == 2'b11) begin
        if (cmp_go) begin
          chk("scan_pos", cmp_pos, pulses);
          pulses++;
          lastp = int'(cmp_pos);
        end
      end else if (state == 2'b10) begin
        chk("report_valid", valid, 1);
        rep = k; m = match; mi = match_index;
        done = 1;
        $display("scan done: pulses=%0d last_pos=%0d report_cycle=%0d match=%0b index=%0d",
                 pulses, lastp, rep, m, mi);
      end else begin
        chk("scan_state", state, 2'b11);
        done = 1;
      end
    end
    if (!done) chk("scan_timeout", 0, 1);
  endtask

  int pulses, lastp, rep;
  logic m;
  logic [5:0] mi;

  initial begin
    // Basic first match: string 8, pattern 3, hit answered for position 2
    for (int i = 0; i < 8; i++) vecs[i] = mk(1, 0, 0, 1, 6'(i), 0, 0, 0, 0, 0, 0, 0, 2'b01);
    for (int i = 0; i < 3; i++) vecs[8 + i] = mk(0, 1, 0, 0, 0, 1, 4'(i), 0, 0, 0, 0, 0, 2'b01);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b11);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b11);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 2'b11);
    vecs[15] = mk(0, 0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 2'b11);
`ifdef SME_SCAN_CTRL_MATCHCNT_EN
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 2'b11);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 2'b11);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 2'b10);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2'b01);
`else
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 2'b10);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2'b01);
`endif

    rst = 1'b1; isstring = 1'b0; ispattern = 1'b0; cmp_hit = 1'b0;
    #1;
    chk("reset_outputs", act_vec, 29'd0);
`ifdef SME_SCAN_CTRL_MATCHCNT_EN
    chk("reset_match_cnt", match_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_after_reset", state, 2'b00);

    for (int i = 0; i < NV; i++) begin
      cyc(vecs[i].s, vecs[i].p, vecs[i].h);
      checks++;
      if (act_vec !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec%0d: got 0x%08h expected 0x%08h", i, act_vec, vecs[i].exp);
      end
    end
    $display("table: %0d vectors applied", NV);
`ifdef SME_SCAN_CTRL_MATCHCNT_EN
    chk("basic_match_cnt", match_cnt, 1);
`endif

    // No match: string 5, pattern 2 -> positions 0..3, report 5 cycles after SCAN entry
    load_str(5, 1'b0);
    load_pat(2);
    cyc(1'b0, 1'b0, 1'b0);
    run_scan(-99, -99, pulses, lastp, rep, m, mi);
    chk("nomatch_pulses", pulses, 4);
    chk("nomatch_last", lastp, 3);
    chk("nomatch_report_cycle", rep, 5);
    chk("nomatch_match", m, 0);
    chk("nomatch_index", mi, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("nomatch_valid_one_cycle", valid, 0);

    // Pattern longer than string: no issue, report right after the single SCAN cycle
    load_str(2, 1'b0);
    load_pat(4);
    cyc(1'b0, 1'b0, 1'b0);
    run_scan(-99, -99, pulses, lastp, rep, m, mi);
    chk("long_pat_pulses", pulses, 0);
    chk("long_pat_report_cycle", rep, 1);
    chk("long_pat_match", m, 0);

    // Saturation at 32 characters, then two patterns against the retained string
    load_str(40, 1'b0);
    load_pat(2);
    cyc(1'b0, 1'b0, 1'b0);
    run_scan(5, -99, pulses, lastp, rep, m, mi);
    chk("sat_p1_match", m, 1);
    chk("sat_p1_index", mi, 5);
`ifdef SME_SCAN_CTRL_MATCHCNT_EN
    chk("sat_p1_pulses", pulses, 31);
    chk("sat_p1_report_cycle", rep, 32);
`else
    chk("sat_p1_pulses", pulses, 7);
    chk("sat_p1_report_cycle", rep, 7);
`endif
    load_pat(3);
    cyc(1'b0, 1'b0, 1'b0);
    run_scan(-99, -99, pulses, lastp, rep, m, mi);
    chk("sat_p2_pulses", pulses, 30);
    chk("sat_p2_last", lastp, 29);
    chk("sat_p2_report_cycle", rep, 31);
    chk("sat_p2_match", m, 0);

    // Both inputs high act as string; hits answered for positions 1 and 4 (L=5)
    load_str(6, 1'b1);
    load_pat(1);
    cyc(1'b0, 1'b0, 1'b0);
    run_scan(1, 4, pulses, lastp, rep, m, mi);
    chk("both_match", m, 1);
    chk("both_index", mi, 1);
`ifdef SME_SCAN_CTRL_MATCHCNT_EN
    chk("both_pulses", pulses, 6);
    chk("both_report_cycle", rep, 7);
    chk("both_match_cnt", match_cnt, 2);
`else
    chk("both_pulses", pulses, 3);
    chk("both_report_cycle", rep, 3);
`endif

    // Reset while position 3 is being issued
    load_str(8, 1'b0);
    load_pat(2);
    cyc(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0);
    chk("pre_reset_go", cmp_go, 1);
    chk("pre_reset_pos", cmp_pos, 3);
    rst = 1'b1;
    #1;
    chk("midscan_reset_outputs", act_vec, 29'd0);
`ifdef SME_SCAN_CTRL_MATCHCNT_EN
    chk("midscan_reset_match_cnt", match_cnt, 0);
`endif
    @(negedge clk);
    #1;
    chk("reset_hold_state", state, 2'b00);
    chk("reset_hold_valid", valid, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("read_after_release", state, 2'b01);
    chk("no_valid_after_release", valid, 0);
    $display("reset mid-scan sequence applied");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
